// File: rtl/ex_operand_forward.sv
// EX-stage operand forwarding and load-use hazard detection for the pipelined MIPS core.
// Tracks the last DEPTH retired-from-EX results and resolves rs/rt with youngest-first priority.
module ex_operand_forward #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_use_rs,
  input  logic              ex_use_rt,
  input  logic [DATA_W-1:0] ex_rs_data,
  input  logic [DATA_W-1:0] ex_rt_data,
  input  logic [DATA_W-1:0] ex_imm,
  input  logic              ex_alusrcb_imm,
  input  logic [DATA_W-1:0] mem_load_data,
  output logic [DATA_W-1:0] src_a,
  output logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Stage 0 is the instruction in MEM; higher indices are older.
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [REG_AW-1:0] rd_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [REG_AW-1:0] src_addr [2];
  logic [DATA_W-1:0] src_rf   [2];
  logic [DATA_W-1:0] res_w    [2];
  logic [1:0]        haz_w;

  assign src_addr[0] = ex_rs;
  assign src_addr[1] = ex_rt;
  assign src_rf[0]   = ex_rs_data;
  assign src_rf[1]   = ex_rt_data;

  // Index 0 resolves rs, index 1 resolves rt.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
      logic [DATA_W-1:0] val;
      logic              hz;

      // Walk oldest to youngest so the youngest match is the last one to win.
      always_comb begin
        val = src_rf[gi];
        hz  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (valid_q[i] && (rd_q[i] == src_addr[gi]) && (|src_addr[gi])) begin
            val = data_q[i];
            hz  = ~ready_q[i];
          end
        end
      end

      assign res_w[gi] = val;
      assign haz_w[gi] = hz;
    end
  endgenerate

  assign src_a      = res_w[0];
  assign store_data = res_w[1];
  assign src_b      = ex_alusrcb_imm ? ex_imm : res_w[1];
  assign stall      = ex_valid && ((haz_w[0] && ex_use_rs) || (haz_w[1] && ex_use_rt));
  assign stall_cnt  = cnt_q;

  // A pending load completes as it leaves stage 0, picking up the memory data.
  always_comb begin
    valid_d   = valid_q;
    ready_d   = ready_q;
    for (int i = 0; i < DEPTH; i++) begin
      rd_d[i]   = rd_q[i];
      data_d[i] = data_q[i];
    end
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      rd_d[i]    = rd_q[i-1];
      ready_d[i] = 1'b1;
      data_d[i]  = ready_q[i-1] ? data_q[i-1] : mem_load_data;
    end
    valid_d[0] = ex_valid && ex_we && (|ex_rd) && !stall;
    rd_d[0]    = ex_rd;
    ready_d[0] = !ex_is_load;
    data_d[0]  = ex_alu_result;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '1;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      cnt_q <= '0;
    end else if (!hold) begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_forward.sv
// Scoreboard bench for ex_operand_forward: a driver pushes model expectations,
// a negedge monitor pops them and compares against the DUT outputs.
module tb_ex_operand_forward;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, hold;
  logic          ex_valid, ex_we, ex_is_load;
  logic [AW-1:0] ex_rd, ex_rs, ex_rt;
  logic [DW-1:0] ex_alu_result, ex_rs_data, ex_rt_data, ex_imm, mem_load_data;
  logic          ex_use_rs, ex_use_rt, ex_alusrcb_imm;
  logic [DW-1:0] src_a, src_b, store_data;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  ex_operand_forward #(.DATA_W(DW), .REG_AW(AW), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_alu_result(ex_alu_result), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_use_rs(ex_use_rs), .ex_use_rt(ex_use_rt),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_alusrcb_imm(ex_alusrcb_imm), .mem_load_data(mem_load_data),
    .src_a(src_a), .src_b(src_b), .store_data(store_data),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference: list of recent register writes, youngest first.
  typedef struct {
    logic          v;
    logic [AW-1:0] rd;
    logic          rdy;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    int            id;
    logic [DW-1:0] a, b, sd;
    logic          chk_a, chk_b, chk_sd;
    logic          st;
    logic [CW-1:0] cnt;
  } exp_t;

  ent_t          hist[$];
  exp_t          exp_q[$];
  logic [CW-1:0] m_cnt;
  int            n_checks = 0;
  int            n_errors = 0;
  int            txn = 0;
  bit            verbose = 1'b1;

  task automatic chk(input string nm, input int id, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s txn=%0d got=%h expected=%h", nm, id, got, want);
    end
  endtask

  task automatic model_reset();
    ent_t e;
    hist.delete();
    e.v = 1'b0; e.rd = '0; e.rdy = 1'b1; e.d = '0;
    for (int i = 0; i < D; i++) hist.push_back(e);
    m_cnt = '0;
  endtask

  task automatic resolve(input logic [AW-1:0] r, input logic [DW-1:0] rf,
                         output logic [DW-1:0] val, output logic haz);
    bit found;
    found = 1'b0;
    val = rf;
    haz = 1'b0;
    for (int i = 0; i < hist.size(); i++) begin
      if (!found && hist[i].v && hist[i].rd == r && r != 0) begin
        found = 1'b1;
        val = hist[i].d;
        haz = !hist[i].rdy;
      end
    end
  endtask

  // Called at posedge+1: push expectation, cross one edge, advance the model.
  task automatic step();
    exp_t e;
    ent_t n, y;
    logic [DW-1:0] va, vt;
    logic hrs, hrt, st;
    resolve(ex_rs, ex_rs_data, va, hrs);
    resolve(ex_rt, ex_rt_data, vt, hrt);
    st = ex_valid && ((hrs && ex_use_rs) || (hrt && ex_use_rt));
    e.id = txn++;
    e.a = va; e.chk_a = !hrs;
    e.sd = vt; e.chk_sd = !hrt;
    e.b = ex_alusrcb_imm ? ex_imm : vt;
    e.chk_b = ex_alusrcb_imm || !hrt;
    e.st = st;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    if (!hold) begin
      if (st && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      y = hist[0];
      if (!y.rdy) begin
        y.rdy = 1'b1;
        y.d = mem_load_data;
        hist[0] = y;
      end
      n.v = ex_valid && ex_we && ex_rd != 0 && !st;
      n.rd = ex_rd;
      n.rdy = !ex_is_load;
      n.d = ex_alu_result;
      hist.push_front(n);
      void'(hist.pop_back());
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (verbose)
        $display("txn %0d: src_a=%h src_b=%h store=%h stall=%0b cnt=%0d",
                 e.id, src_a, src_b, store_data, stall, stall_cnt);
      chk("stall", e.id, {31'b0, stall}, {31'b0, e.st});
      chk("stall_cnt", e.id, DW'(stall_cnt), DW'(e.cnt));
      if (e.chk_a)  chk("src_a", e.id, src_a, e.a);
      if (e.chk_b)  chk("src_b", e.id, src_b, e.b);
      if (e.chk_sd) chk("store_data", e.id, store_data, e.sd);
    end
  end

  task automatic nop();
    hold = 0; ex_valid = 0; ex_we = 0; ex_is_load = 0;
    ex_rd = 0; ex_rs = 0; ex_rt = 0; ex_use_rs = 0; ex_use_rt = 0;
    ex_rs_data = 32'h11; ex_rt_data = 32'h22; ex_imm = 0; ex_alusrcb_imm = 0;
    ex_alu_result = 0; mem_load_data = 0;
  endtask

  task automatic wr(input logic [AW-1:0] rd, input logic [DW-1:0] val, input logic ld);
    nop(); ex_valid = 1; ex_we = 1; ex_is_load = ld; ex_rd = rd; ex_alu_result = val;
    step();
  endtask

  task automatic rdop(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic urs, input logic urt);
    nop(); ex_valid = 1; ex_rs = rs; ex_rt = rt; ex_use_rs = urs; ex_use_rt = urt;
    step();
  endtask

  initial begin
    rst = 1'b1;
    nop();
    model_reset();
    #3;
    chk("reset_src_a", -1, src_a, 32'h11);
    chk("reset_src_b", -1, src_b, 32'h22);
    chk("reset_stall", -1, {31'b0, stall}, 32'h0);
    chk("reset_cnt", -1, DW'(stall_cnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Forwarding across every tracked stage, then retirement.
    wr(5, 32'hA5, 0);
    for (int i = 0; i < D + 1; i++) rdop(5, 0, 1, 0);
    // Youngest wins; r0 never forwards.
    wr(7, 32'h1, 0); wr(7, 32'h2, 0); rdop(7, 7, 1, 1);
    wr(0, 32'hFF, 0); rdop(0, 0, 1, 1);
    // Load-use on rt.
    wr(3, 32'hBAD, 1);
    nop(); ex_valid = 1; ex_rt = 3; ex_use_rt = 1; mem_load_data = 32'hDEAD; step();
    nop(); ex_valid = 1; ex_rt = 3; ex_use_rt = 1; step();
    // Immediate B with rt matched in s[1].
    wr(4, 32'h44, 0); wr(9, 32'h99, 0);
    nop(); ex_valid = 1; ex_rt = 4; ex_alusrcb_imm = 1; ex_imm = 32'h10; step();
    // Hold during a hazard.
    wr(6, 32'h77, 1);
    for (int i = 0; i < 3; i++) begin
      nop(); ex_valid = 1; ex_rs = 6; ex_use_rs = 1; hold = 1; mem_load_data = 32'hCAFE; step();
    end
    nop(); ex_valid = 1; ex_rs = 6; ex_use_rs = 1; mem_load_data = 32'hCAFE; step();
    rdop(6, 6, 1, 1);

    // Randomized traffic over a small register set to provoke matches and saturation.
    verbose = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ex_valid = $urandom_range(0, 9) != 0;
      ex_we = $urandom_range(0, 3) != 0;
      ex_is_load = $urandom_range(0, 2) == 0;
      ex_rd = AW'($urandom_range(0, 3));
      ex_rs = AW'($urandom_range(0, 3));
      ex_rt = AW'($urandom_range(0, 3));
      ex_use_rs = 1'($urandom);
      ex_use_rt = 1'($urandom);
      ex_rs_data = $urandom; ex_rt_data = $urandom; ex_imm = $urandom;
      ex_alu_result = $urandom; mem_load_data = $urandom;
      ex_alusrcb_imm = 1'($urandom);
      hold = $urandom_range(0, 6) == 0;
      step();
    end
    verbose = 1'b1;

    // Asynchronous reset while a hazard is showing.
    wr(3, 32'h1234, 1);
    nop(); ex_valid = 1; ex_rt = 3; ex_use_rt = 1; ex_rs_data = 32'h5A;
    #1;
    chk("hazard_before_rst", -2, {31'b0, stall}, 32'h1);
    rst = 1'b1;
    #1;
    chk("stall_after_rst", -2, {31'b0, stall}, 32'h0);
    chk("src_a_after_rst", -2, src_a, 32'h5A);
    chk("cnt_after_rst", -2, DW'(stall_cnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    rdop(3, 3, 1, 1);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ex_operand_forward.md
# ex_operand_forward

Parametrised EX-stage operand forwarding and load-use hazard unit for the pipelined MIPS core. It tracks the destination register, readiness and result of the last DEPTH instructions that have left EX, and resolves both ALU source operands and the store-data operand for the instruction currently in EX. It raises a one-cycle `stall` on a load-use hazard and inserts a bubble into its own tracking pipeline. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- `DATA_W`, 32, datapath width.
- `REG_AW`, 5, register address width.
- `DEPTH`, 3, tracked in-flight stages after EX (s[0]=MEM, s[1]=WB, s[2]=post-WB); legal range 2..8.
- `CNT_W`, 16, stall counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `hold` in 1: global pipeline freeze (e.g. memory wait); the tracking pipeline and counter do not update.
- `ex_valid` in 1: the EX slot holds a real instruction.
- `ex_we` in 1: the EX instruction writes a register.
- `ex_is_load` in 1: the EX instruction is a load; its data is not ready until MEM.
- `ex_rd` in REG_AW: EX destination register.
- `ex_alu_result` in DATA_W: EX result, captured into s[0].
- `ex_rs`, `ex_rt` in REG_AW: EX source register addresses.
- `ex_use_rs`, `ex_use_rt` in 1: the EX instruction actually consumes rs/rt.
- `ex_rs_data`, `ex_rt_data` in DATA_W: register-file values latched in ID/EX.
- `ex_imm` in DATA_W: extended immediate.
- `ex_alusrcb_imm` in 1: ALU B takes the immediate.
- `mem_load_data` in DATA_W: load data for the instruction in s[0].
- `src_a` out DATA_W: resolved ALU operand A.
- `src_b` out DATA_W: resolved ALU operand B.
- `store_data` out DATA_W: resolved rt value, used as store data.
- `stall` out 1: load-use hazard; hold PC, IF/ID and ID/EX this cycle.
- `stall_cnt` out CNT_W: saturating count of stall cycles.

## Operation
- **Entry state.** Each s[i] holds `valid`, `rd`, `ready` and `data`.
- **Match rule.** Entry i matches source register r when `valid && rd == r && r != 0`. Register 0 never matches and always uses register-file data.
- **Lookup priority.** For each of rs and rt, search youngest first: s[0], then s[1], and so on. The first match supplies the value: `data` if `ready`. If s[0] matches and is not ready, the lookup is a hazard. With no match, use `ex_rs_data` / `ex_rt_data`.
- **Operand outputs.**
  - `src_a` = resolved rs.
  - `store_data` = resolved rt.
  - `src_b` = `ex_imm` if `ex_alusrcb_imm`, else resolved rt.
- **Stall.** `stall` = (hazard on rs && `ex_use_rs`) || (hazard on rt && `ex_use_rt`). Hazard checks apply only when `ex_valid`. An immediate-B instruction still stalls if `ex_use_rt` is set (store data).
- **Shift.** On every rising edge with `hold` = 0:
  - s[i] <= s[i-1] for i >= 1. If s[i-1] is not ready, s[i] takes ready=1 and data=`mem_load_data`.
  - s[0] <= {valid = `ex_valid && ex_we && ex_rd != 0 && !stall`, rd = `ex_rd`, ready = `!ex_is_load`, data = `ex_alu_result`}.
  - A stall therefore inserts a bubble (valid=0) into s[0]. The entry in s[DEPTH-1] retires, because the register file now holds it.
- **Stall counter.** `stall_cnt` increments when `stall && !hold`. It saturates at all-ones.
- **Hold.** With `hold` = 1 no state changes. Outputs still track inputs combinationally.

## Timing
- **Reset.** On `rst` (async): all entries invalid, ready=1, data=0, `stall_cnt`=0. Consequently `stall`=0, `src_a`=`ex_rs_data`, `src_b`=`ex_rt_data` or `ex_imm`, `store_data`=`ex_rt_data`. Reset mid-stall clears the stall immediately, without waiting for a clock edge.
- **Outputs.** All operand outputs and `stall` are combinational from the inputs and the stage registers, with zero-cycle latency.
- **Capture.** An EX result becomes forwardable one cycle later (from s[0]) and stays forwardable for DEPTH cycles.
- **Load-use.** Costs exactly one stall cycle per edge without `hold`. At the next edge the load moves to s[1] with `mem_load_data` captured, so the re-presented EX instruction gets the load value and `stall` drops.
- **Hold during a hazard.** `stall` remains asserted, the counter does not increment, and nothing shifts. `mem_load_data` must stay valid until the first non-hold edge.
- **Simultaneous matches.** When the same rd appears in several stages, the youngest stage wins. When rs == rt, both operands resolve identically.

## Test plan
1. **Reset.** Assert `rst` with `ex_rs_data`=0x11, `ex_rt_data`=0x22 → `src_a`=0x11, `src_b`=0x22, `stall`=0, `stall_cnt`=0.
2. **Forward from s[0].** Issue `add` with rd=5, result 0xA5. Next cycle, EX reads rs=5 → `src_a`=0xA5, `stall`=0. Two cycles later (s[1]) → still 0xA5. After DEPTH+1 cycles → `ex_rs_data`.
3. **Youngest wins.** Write rd=7 with 0x1, then rd=7 with 0x2. The reader sees 0x2. A write to rd=0 with 0xFF followed by a read of r0 → the register-file value.
4. **Load-use.** Load rd=3, followed by an instruction using rt=3 with `ex_use_rt`=1 → `stall`=1 for one cycle. With `mem_load_data`=0xDEAD at that edge, the next cycle gives `store_data`=0xDEAD, `stall`=0, `stall_cnt`=1, and s[0] is a bubble.
5. **Immediate B.** `ex_alusrcb_imm`=1, `ex_imm`=0x10, rt=4 matched in s[1] with 0x44 → `src_b`=0x10, `store_data`=0x44.
6. **Hold and saturation.** With `hold`=1 during a load-use hazard → `stall` stays 1 for 3 cycles and `stall_cnt` is unchanged. With `CNT_W`=2, four stalls → `stall_cnt`=3. An async `rst` mid-hazard → `stall`=0 immediately.
